// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM encoding, requester IDs and
// default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles both cache-side request/response ports and the memory-side port
// of the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  // Handshake: a cache raises x_read/x_write and holds it, together with its
  // address/data, until it sees x_ready for one cycle. The memory sees a
  // strobe held with stable address/data until it returns a one-cycle
  // mem_ready pulse; mem_rdata is valid only with that pulse.
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic [CNT_W-1:0]  i_grant_cnt;
  logic [CNT_W-1:0]  d_grant_cnt;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, i_grant_cnt, d_grant_cnt
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata, i_grant_cnt, d_grant_cnt
  );
endinterface

// File: rtl/rr_pick2.sv
// Two-way grant picker: D wins when alone, when D-priority is set, or when I
// was the last one served; otherwise I wins.
import mem_arb_pkg::*;

module rr_pick2 (
  input  logic    req_i,
  input  logic    req_d,
  input  req_id_t last_grant,
  input  logic    d_prio,
  output logic    grant_i,
  output logic    grant_d
);

  always_comb begin
    grant_d = req_d & (~req_i | d_prio | (last_grant == REQ_I));
    grant_i = req_i & ~grant_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache block transactions onto one memory port and
// routes each response back to the cache that owned the transaction.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int D_PRIO = 0,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output state_t        state_o
);

  state_t            state_q, state_d;
  req_id_t           last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;

  logic req_i, req_d, grant_i, grant_d;

  assign req_i = bus.i_read;
  assign req_d = bus.d_read | bus.d_write;

  rr_pick2 u_pick (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant_q),
    .d_prio     (D_PRIO != 0),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_cnt_d      = i_cnt_q;
    d_cnt_d      = d_cnt_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = BUSY_I;
          mem_read_d   = 1'b1;
          mem_write_d  = 1'b0;
          mem_addr_d   = bus.i_addr;
          last_grant_d = REQ_I;
          i_cnt_d      = (&i_cnt_q) ? i_cnt_q : i_cnt_q + CNT_W'(1);
        end else if (grant_d) begin
          // A write-back takes precedence over a read raised alongside it.
          state_d      = BUSY_D;
          mem_write_d  = bus.d_write;
          mem_read_d   = ~bus.d_write;
          mem_addr_d   = bus.d_addr;
          mem_wdata_d  = bus.d_wdata;
          last_grant_d = REQ_D;
          d_cnt_d      = (&d_cnt_q) ? d_cnt_q : d_cnt_q + CNT_W'(1);
        end
      end
      BUSY_I: begin
        if (bus.mem_ready) begin
          state_d     = RESP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          i_rdata_d   = bus.mem_rdata;
          i_ready_d   = 1'b1;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          state_d     = RESP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          d_rdata_d   = bus.mem_rdata;
          d_ready_d   = 1'b1;
        end
      end
      // The owner still holds its request while its ready is high, so
      // arbitration waits for IDLE.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_D;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_cnt_q      <= '0;
      d_cnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_cnt_q      <= i_cnt_d;
      d_cnt_q      <= d_cnt_d;
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.i_ready     = i_ready_q;
  assign bus.d_ready     = d_ready_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.i_grant_cnt = i_cnt_q;
  assign bus.d_grant_cnt = d_cnt_q;
  assign state_o         = state_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the I-cache and D-cache miss/write-back requests of the pipelined RISC-V core.
- Sits between the two caches' memory-side interfaces and the off-chip memory model.
- Serialises one transaction at a time. Arbitrates round-robin, or with fixed D-cache priority.
- Returns the response only to the granted cache.

Parameters:
- ADDR_W, 28, memory block address width (32-bit byte address minus 4 offset bits).
- DATA_W, 128, memory block width (4 words).
- D_PRIO, 0, 1 = D-cache always wins a conflict; 0 = round-robin on conflict.
- CNT_W, 16, width of the saturating grant counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low, sampled on posedge clk
- i_read  in  1  I-cache read request, held until i_ready
- i_addr  in  ADDR_W  I-cache block address
- i_ready  out  1  one-cycle response pulse to I-cache
- i_rdata  out  DATA_W  block data to I-cache, valid when i_ready
- d_read  in  1  D-cache read request, held until d_ready
- d_write  in  1  D-cache write request, held until d_ready
- d_addr  in  ADDR_W  D-cache block address
- d_wdata  in  DATA_W  D-cache write data
- d_ready  out  1  one-cycle response pulse to D-cache
- d_rdata  out  DATA_W  block data to D-cache, valid when d_ready
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory completion pulse
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- i_grant_cnt  out  CNT_W  number of I-cache transactions granted, saturating
- d_grant_cnt  out  CNT_W  number of D-cache transactions granted, saturating

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, RESP. All outputs are registered.
- Reset (rst_n=0 at posedge):
  - state=IDLE; all mem_* and *_ready = 0; *_rdata, mem_addr, mem_wdata = 0.
  - Counters = 0; last_grant = D, so the first conflict goes to I.
  - A reset during BUSY abandons the memory transaction; mem_read/mem_write drop on that edge.
- IDLE:
  - Only i_read pending: grant I. Next state BUSY_I; mem_read=1, mem_addr=i_addr.
  - Only D pending (d_read|d_write): grant D. Next state BUSY_D; mem_addr=d_addr, mem_wdata=d_wdata.
    - d_write=1 gives mem_write=1, mem_read=0.
    - d_write has precedence when both d_read and d_write are high; mem_read and mem_write are never both 1.
  - Both pending: D_PRIO=1 grants D. D_PRIO=0 grants the requester not equal to last_grant. last_grant updates on grant.
  - On each grant, the matching counter increments, saturating at all-ones.
- BUSY_x:
  - Hold mem_* stable until mem_ready=1.
  - On mem_ready: next state RESP; mem_read/mem_write drop to 0 on the same edge.
  - Owner's x_ready=1 in the next cycle. x_rdata = mem_rdata captured on the mem_ready edge; for writes, don't-care but still captured.
  - Latency: x_ready appears exactly 1 cycle after mem_ready.
  - Minimum turnaround is request seen in IDLE → mem strobe next cycle.
- RESP:
  - Exactly one cycle; x_ready is high for this single cycle.
  - New requests are ignored in RESP, because the owner still holds its request during the ready cycle.
  - Next state IDLE, where arbitration resumes; a waiting requester is granted then.
- x_rdata holds its value after x_ready until the next response to the same requester.
- A request deasserted by a cache before grant is simply not served; no error flag.

Decomposition:
- Shared package `mem_arb_pkg`: state encoding localparams (IDLE, BUSY_I, BUSY_D, RESP), requester IDs (REQ_I, REQ_D), default ADDR_W/DATA_W.
- One natural sub-module: `rr_pick2`, a combinational 2-way picker taking req_i, req_d, last_grant and d_prio, returning grant_i and grant_d.
- The saturating counters stay inline.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with i_read=1 → all outputs 0. After release, mem_read=1 and mem_addr=i_addr appear one cycle later.
- Single I read, addr 0x0000010, memory ready after 5 cycles with rdata 0xDEADBEEF_... → i_ready pulses 1 cycle after mem_ready with that data; d_ready stays 0; i_grant_cnt=1.
- D write with d_read=d_write=1, addr 0x00000A0, wdata 0x1122... → mem_write=1, mem_read=0, mem_wdata matches; d_ready pulses once.
- Simultaneous i_read and d_read, held, D_PRIO=0 → grant order I, D, I, D over 4 transactions. With D_PRIO=1 → D served until d_read drops.
- Back-to-back: D re-requests in the cycle after d_ready → no grant in RESP; grant in IDLE; no double-serve of the first request.
- Reset asserted while BUSY_D → next cycle mem_write=0, state IDLE, a late mem_ready is ignored, counters=0.
